io_ctrl: RTL



---
 rtl/io_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: 16-entry window with four output ports, four synchronised inputs,
// and an optional prescaled down-counting timer with overflow irq (enabled by defining IO_TIMER_EN).
module io_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          PRESC     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Direcciones,
  inout  wire  [15:0] Datos,
  input  logic        we,
  input  logic        oe,
  input  logic [15:0] in_port0,
  input  logic [15:0] in_port1,
  input  logic [15:0] in_port2,
  input  logic [15:0] in_port3,
  output logic [15:0] out_port0,
  output logic [15:0] out_port1,
  output logic [15:0] out_port2,
  output logic [15:0] out_port3,
  output logic        irq
);

  if (PRESC < 1 || PRESC > 65535) begin : g_bad_presc
    $error("io_ctrl: PRESC out of range 1..65535");
  end

  logic             sel, wr, rd;
  logic [3:0]       off;
  logic [15:0]      rdata;
  logic [3:0][15:0] out_q, sync1_q, sync2_q, in_w;

  assign sel = (Direcciones[15:4] == BASE_ADDR[15:4]);
  assign off = Direcciones[3:0];
  assign wr  = sel & we;
  assign rd  = sel & oe & ~we;

  assign Datos = rd ? rdata : 16'hzzzz;

  assign in_w      = {in_port3, in_port2, in_port1, in_port0};
  assign out_port0 = out_q[0];
  assign out_port1 = out_q[1];
  assign out_port2 = out_q[2];
  assign out_port3 = out_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_w;
      sync2_q <= sync1_q;
      if (wr && off[3:2] == 2'b00) out_q[off[1:0]] <= Datos;
    end
  end

`ifdef IO_TIMER_EN
  localparam logic [15:0] PMAX = 16'(PRESC - 1);

  logic [15:0] reload_q, reload_d, count_q, count_d, presc_q, presc_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d, tick;

  assign tick = ctrl_q[0] && (presc_q == PMAX);
  assign irq  = ovf_q & ctrl_q[2];

  // Statement order encodes priority: overflow set beats status clear,
  // software writes to reload/ctrl beat the timer's own update.
  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    ovf_d    = ovf_q;
    presc_d  = (!ctrl_q[0] || tick) ? 16'd0 : presc_q + 16'd1;
    if (wr && off == 4'hB && Datos[0]) ovf_d = 1'b0;
    if (tick) begin
      if (count_q != 16'd0) count_d = count_q - 16'd1;
      else begin
        ovf_d = 1'b1;
        if (ctrl_q[1]) count_d = reload_q;
        else ctrl_d[0] = 1'b0;
      end
    end
    if (wr && off == 4'h8) begin
      reload_d = Datos;
      count_d  = Datos;
      presc_d  = 16'd0;
    end
    if (wr && off == 4'hA) begin
      ctrl_d = Datos[2:0];
      if (Datos[0]) presc_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      ctrl_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      ctrl_q   <= ctrl_d;
      ovf_q    <= ovf_d;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      4'h0, 4'h1, 4'h2, 4'h3: rdata = out_q[off[1:0]];
      4'h4, 4'h5, 4'h6, 4'h7: rdata = sync2_q[off[1:0]];
`ifdef IO_TIMER_EN
      4'h8: rdata = reload_q;
      4'h9: rdata = count_q;
      4'hA: rdata = {13'd0, ctrl_q};
      4'hB: rdata = {15'd0, ovf_q};
`endif
      default: rdata = '0;
    endcase
  end

endmodule
